dmem_dump: RTL and testbench

Sequential readback engine for the CPU v3 data memory. On a start pulse it walks DMEM addresses 0..NWORDS-1 through a synchronous read port and streams each byte out on a valid/ready interface, flagging the last byte. It also accumulates an 8-bit modular checksum. It is the read-out counterpart to the DMEM preload path: after a program run it lets the bench or board-level logic dump and verify memory contents.

---
 rtl/dmem_dump.sv | 84 ++++++++
 tb/tb_dmem_dump.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_dump.sv
// dmem_dump: walks DMEM addresses 0..NWORDS-1 through a 1-cycle-latency read port,
// streams each byte on a valid/ready port flagging the last, and keeps a modular checksum.
module dmem_dump #(
    parameter int NWORDS = 8,
    parameter int AW     = 3,
    parameter int DW     = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          ren_o,
    output logic [AW-1:0] raddr_o,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] tdata_o,
    output logic          tvalid_o,
    input  logic          tready_i,
    output logic          tlast_o,
    output logic [DW-1:0] csum_o
);
    typedef enum logic [2:0] {IDLE, READ, CAP, SEND, FIN} state_t;
    localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, raddr_q, raddr_d;
    logic [DW-1:0] tdata_q, tdata_d, csum_q, csum_d;
    logic          last;
    assign last = cnt_q == LAST;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        tdata_d = tdata_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = READ;
                cnt_d   = '0;
                raddr_d = '0;
                csum_d  = '0;
            end
            READ: state_d = CAP;
            CAP: begin
                tdata_d = rdata_i;
                state_d = SEND;
            end
            // raddr is loaded on entry to READ so it stays put everywhere else
            SEND: if (tready_i) begin
                csum_d = csum_q + tdata_q;
                if (last) state_d = FIN;
                else begin
                    cnt_d   = cnt_q + 1'b1;
                    raddr_d = cnt_q + 1'b1;
                    state_d = READ;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            tdata_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            tdata_q <= tdata_d;
            csum_q  <= csum_d;
        end
    end
    assign busy_o   = state_q != IDLE;
    assign done_o   = state_q == FIN;
    assign ren_o    = state_q == READ;
    assign tvalid_o = state_q == SEND;
    assign tlast_o  = tvalid_o && last;
    assign raddr_o  = raddr_q;
    assign tdata_o  = tdata_q;
    assign csum_o   = csum_q;
endmodule

// File: tb/tb_dmem_dump.sv
// tb_dmem_dump: randomized and directed stimulus against a cycle-level behavioural model
// of the dump sequence, plus literal expectations for checksum and latency.
module tb_dmem_dump;
    localparam int NW = 8;
    logic       clk, rst_n, start, busy, done, ren, tvalid, tready, tlast;
    logic [2:0] raddr;
    logic [7:0] rdata, tdata, csum;
    logic       s_start, s_busy, s_done, s_ren, s_tvalid, s_tlast;
    logic [2:0] s_raddr;
    logic [7:0] s_rdata, s_tdata, s_csum;
    logic [7:0] mem [NW];
    logic [7:0] snap [NW];
    logic [7:0] tv [NW] = '{8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h18, 8'h00};
    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    bit active = 0;
    int idx, send_at, fin_at, acc_cyc, done_cyc, xfers = 0, dones = 0;
    logic [7:0] csum_e = 0, tdata_e = 0;
    logic [2:0] raddr_e = 0;

    dmem_dump #(.NWORDS(8), .AW(3), .DW(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .ren_o(ren), .raddr_o(raddr), .rdata_i(rdata), .tdata_o(tdata), .tvalid_o(tvalid),
        .tready_i(tready), .tlast_o(tlast), .csum_o(csum));

    dmem_dump #(.NWORDS(1), .AW(3), .DW(8)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
        .ren_o(s_ren), .raddr_o(s_raddr), .rdata_i(s_rdata), .tdata_o(s_tdata), .tvalid_o(s_tvalid),
        .tready_i(1'b1), .tlast_o(s_tlast), .csum_o(s_csum));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ren) rdata <= mem[raddr];
    always @(posedge clk) if (s_ren) s_rdata <= (s_raddr == 3'd0) ? 8'h5A : 8'h00;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Expected behaviour per cycle: a dump is a list of words, each READ/CAP/SEND with SEND
    // lasting until the sink accepts, then one FIN cycle.
    task automatic model_check();
        if (!rst_n) begin
            chk("rst_outs", {busy, done, ren, tvalid, tlast, raddr, tdata, csum}, 0);
            active = 0; csum_e = 0; raddr_e = 0; tdata_e = 0;
        end else begin
            if (active && cyc == send_at - 2 && cyc != fin_at) raddr_e = 3'(idx);
            chk("csum", csum, csum_e);
            chk("raddr", raddr, raddr_e);
            if (!active) begin
                chk("idle_ctl", {busy, done, ren, tvalid, tlast}, 0);
                chk("idle_tdata", tdata, tdata_e);
                if (start) begin
                    active = 1; idx = 0; acc_cyc = cyc; send_at = cyc + 3; fin_at = -1; csum_e = 0;
                    snap = mem;
                end
            end else if (cyc == fin_at) begin
                chk("fin_ctl", {busy, done, ren, tvalid, tlast}, 5'b11000);
                chk("fin_tdata", tdata, tdata_e);
                dones++; done_cyc = cyc; active = 0;
            end else if (cyc < send_at) begin
                chk("rd_ctl", {busy, done, ren, tvalid, tlast}, {1'b1, 1'b0, cyc == send_at - 2, 2'b00});
                chk("rd_tdata", tdata, tdata_e);
            end else begin
                tdata_e = snap[idx];
                chk("send_ctl", {busy, done, ren, tvalid, tlast}, {3'b100, 1'b1, idx == NW - 1});
                chk("send_tdata", tdata, tdata_e);
                if (tready) begin
                    csum_e += tdata_e; xfers++;
                    if (idx == NW - 1) fin_at = cyc + 1;
                    else begin idx++; send_at = cyc + 3; end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #2;
    endtask

    task automatic dump(input bit rnd, input bit stall, input bit extra, output int dx, output int dd);
        int x0, d0, n, st;
        x0 = xfers; d0 = dones; n = 0; st = 0;
        tready = 1; start = 1;
        step();
        start = 0;
        while (dones == d0 && n < 400) begin
            step();
            n++;
            start = extra && (n == 3 || n == 9);
            if (stall && st == 0 && tvalid && tdata == 8'h04) begin tready = 0; st = 1; end
            else if (st >= 1 && st < 5) st++;
            else if (st == 5) begin tready = 1; st = 6; end
            else if (rnd) tready = 1'($urandom_range(0, 1));
        end
        if (dones == d0) chk("done_timeout", 0, 1);
        start = 0; tready = 1;
        dx = xfers - x0; dd = dones - d0;
    endtask

    initial begin
        int dx, dd, n, d0;
        logic [7:0] s;
        rst_n = 0; start = 0; tready = 1; s_start = 0;
        foreach (mem[i]) mem[i] = 8'h00;
        step(); step();
        chk("reset_state", {busy, done, ren, tvalid, tlast, raddr, tdata, csum}, 0);
        rst_n = 1;
        step();

        foreach (mem[i]) mem[i] = tv[i];
        dump(0, 0, 0, dx, dd);
        chk("t1_csum", csum, 8'h0B); chk("t1_lat", done_cyc - acc_cyc, 25);
        chk("t1_xfers", dx, 8); chk("t1_dones", dd, 1);

        dump(0, 1, 0, dx, dd);
        chk("t2_csum", csum, 8'h0B); chk("t2_lat", done_cyc - acc_cyc, 30); chk("t2_xfers", dx, 8);

        foreach (mem[i]) mem[i] = 8'hFF;
        dump(0, 0, 0, dx, dd);
        chk("ff_csum", csum, 8'hF8); chk("ff_lat", done_cyc - acc_cyc, 25);
        foreach (mem[i]) mem[i] = 8'h00;
        dump(0, 0, 0, dx, dd);
        chk("zero_csum", csum, 8'h00);

        foreach (mem[i]) mem[i] = tv[i];
        dump(0, 0, 1, dx, dd);
        chk("extra_xfers", dx, 8); chk("extra_dones", dd, 1); chk("extra_csum", csum, 8'h0B);

        start = 1; step(); start = 0;
        n = 0;
        while (!(tvalid && raddr == 3'd3) && n < 100) begin step(); n++; end
        chk("rst_reach_w3", n < 100, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_outs", {busy, done, ren, tvalid, tlast, raddr, tdata, csum}, 0);
        d0 = dones;
        step(); step();
        rst_n = 1;
        step();
        chk("rst_no_done", dones - d0, 0);
        dump(0, 0, 0, dx, dd);
        chk("post_rst_csum", csum, 8'h0B); chk("post_rst_xfers", dx, 8);

        s_start = 1; step(); s_start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("n1_ctl", {s_busy, s_done, s_ren, s_tvalid, s_tlast}, {i <= 3, i == 3, i == 0, i == 2, i == 2});
            if (i == 2) chk("n1_tdata", s_tdata, 8'h5A);
            if (i == 3) chk("n1_csum", s_csum, 8'h5A);
            step();
        end

        for (int r = 0; r < 4; r++) begin
            s = 0;
            foreach (mem[i]) begin mem[i] = 8'($urandom); s += mem[i]; end
            dump(1, 0, 0, dx, dd);
            chk("rnd_csum", csum, s); chk("rnd_xfers", dx, 8); chk("rnd_dones", dd, 1);
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
